// File: rtl/ospi_host_ctrl.sv
// Host-side 8-bit SDR OSPI master: one request becomes one CS-framed CMD/ADDR/DUMMY/DATA burst, two clk cycles per beat.
// Latency: rsp_valid the cycle after the last beat; req_ready stays low until CS_IDLE_CYCLES later, and requests are never queued.
module ospi_host_ctrl #(
    parameter int WIDTH          = 8,
    parameter int ADDR_BYTES     = 1,
    parameter int DUMMY_CYCLES   = 4,
    parameter int CS_IDLE_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [1:0]                    req_op,
    input  logic [WIDTH*ADDR_BYTES-1:0]   req_addr,
    input  logic [WIDTH-1:0]              req_wdata,
    output logic                          rsp_valid,
    output logic [WIDTH-1:0]              rsp_rdata,
    output logic                          OSPI_CLK,
    output logic                          OSPI_CS,
    output logic [WIDTH-1:0]              io_out,
    output logic                          io_oe,
    input  logic [WIDTH-1:0]              io_in
);
    localparam int AW = WIDTH * ADDR_BYTES;
    localparam int CW = 8;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;
    localparam logic [1:0] OP_WREN  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_HOLD
    } state_t;

    state_t            r_state;
    logic              r_phase;
    logic [CW-1:0]     r_cnt;
    logic [1:0]        r_op;
    logic [AW-1:0]     r_addr;
    logic [WIDTH-1:0]  r_wdata;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [WIDTH-1:0]  r_rsp_rdata;
    logic              r_ospi_clk;
    logic              r_ospi_cs;
    logic [WIDTH-1:0]  r_io_out;
    logic              r_io_oe;
    logic              w_last;

    function automatic logic [WIDTH-1:0] f_opcode(input logic [1:0] op);
        logic [7:0] code;
        case (op)
            OP_READ:  code = 8'h0B;
            OP_WRITE: code = 8'h02;
            OP_ERASE: code = 8'h20;
            default:  code = 8'h06;
        endcase
        return WIDTH'(code);
    endfunction

    // High during phase1 of the final beat of the frame, whichever phase that is for this op.
    always_comb begin
        w_last = 1'b0;
        if (r_phase) begin
            w_last = (r_state == S_DATA)
                  || (r_state == S_CMD  && r_op == OP_WREN)
                  || (r_state == S_ADDR && r_cnt == '0 && r_op == OP_ERASE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_phase     <= 1'b0;
            r_cnt       <= '0;
            r_op        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_ospi_clk  <= 1'b0;
            r_ospi_cs   <= 1'b1;
            r_io_out    <= '0;
            r_io_oe     <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_req_ready && req_valid) begin
                        r_op        <= req_op;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_state     <= S_CMD;
                        r_phase     <= 1'b0;
                        r_ospi_cs   <= 1'b0;
                        r_ospi_clk  <= 1'b0;
                        r_io_out    <= f_opcode(req_op);
                        r_io_oe     <= 1'b1;
                        r_req_ready <= 1'b0;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    if (!r_phase) begin
                        r_phase    <= 1'b1;
                        r_ospi_clk <= 1'b1;
                    end else begin
                        r_phase    <= 1'b0;
                        r_ospi_clk <= 1'b0;
                        if (w_last) begin
                            if (r_state == S_DATA && r_op == OP_READ)
                                r_rsp_rdata <= io_in;
                            r_rsp_valid <= 1'b1;
                            r_ospi_cs   <= 1'b1;
                            r_io_oe     <= 1'b0;
                            r_io_out    <= '0;
                            if (CS_IDLE_CYCLES == 0) begin
                                r_state     <= S_IDLE;
                                r_req_ready <= 1'b1;
                            end else begin
                                r_state <= S_HOLD;
                                r_cnt   <= CW'(CS_IDLE_CYCLES - 1);
                            end
                        end else begin
                            case (r_state)
                                S_CMD: begin
                                    r_state  <= S_ADDR;
                                    r_cnt    <= CW'(ADDR_BYTES - 1);
                                    r_io_out <= r_addr[AW-1 -: WIDTH];
                                    r_addr   <= r_addr << WIDTH;
                                end
                                S_ADDR: begin
                                    if (r_cnt != '0) begin
                                        r_cnt    <= r_cnt - CW'(1);
                                        r_io_out <= r_addr[AW-1 -: WIDTH];
                                        r_addr   <= r_addr << WIDTH;
                                    end else if (r_op == OP_READ && DUMMY_CYCLES > 0) begin
                                        r_state  <= S_DUMMY;
                                        r_cnt    <= CW'(DUMMY_CYCLES - 1);
                                        r_io_oe  <= 1'b0;
                                        r_io_out <= '0;
                                    end else begin
                                        r_state  <= S_DATA;
                                        r_io_oe  <= (r_op == OP_WRITE);
                                        r_io_out <= (r_op == OP_WRITE) ? r_wdata : '0;
                                    end
                                end
                                S_DUMMY: begin
                                    if (r_cnt != '0)
                                        r_cnt <= r_cnt - CW'(1);
                                    else
                                        r_state <= S_DATA;
                                end
                                default: begin
                                    r_state   <= S_IDLE;
                                    r_ospi_cs <= 1'b1;
                                    r_io_oe   <= 1'b0;
                                    r_io_out  <= '0;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign OSPI_CLK  = r_ospi_clk;
    assign OSPI_CS   = r_ospi_cs;
    assign io_out    = r_io_out;
    assign io_oe     = r_io_oe;
endmodule

// File: tb/tb_ospi_host_ctrl.sv
// Directed bench for ospi_host_ctrl with a behavioural flash on the pad signals.
module tb_ospi_host_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       OSPI_CLK;
    logic       OSPI_CS;
    logic [7:0] io_out;
    logic       io_oe;
    logic [7:0] io_in;

    int checks = 0;
    int errors = 0;

    ospi_host_ctrl #(
        .WIDTH(8), .ADDR_BYTES(1), .DUMMY_CYCLES(4), .CS_IDLE_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .OSPI_CLK(OSPI_CLK), .OSPI_CS(OSPI_CS),
        .io_out(io_out), .io_oe(io_oe), .io_in(io_in)
    );

    always #5 clk = ~clk;

    // Flash model: beat 0 opcode, beat 1 address, beat 2 write data; read data on beat 7 (after 4 dummies).
    logic [7:0] mem [0:255];
    int         beat = 0;
    logic [7:0] f_cmd = 8'h00;
    logic [7:0] f_addr = 8'h00;

    always @(posedge OSPI_CLK or posedge OSPI_CS) begin
        if (OSPI_CS === 1'b1) begin
            beat <= 0;
        end else begin
            case (beat)
                0: f_cmd <= io_out;
                1: begin
                    f_addr <= io_out;
                    if (f_cmd == 8'h20) mem[io_out] <= 8'hFF;
                end
                2: if (f_cmd == 8'h02) mem[f_addr] <= io_out;
                default: ;
            endcase
            beat <= beat + 1;
        end
    end

    assign io_in = (OSPI_CS === 1'b0 && f_cmd == 8'h0B && beat == 7) ? mem[f_addr] : 8'h00;

    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        req_op = op; req_addr = a; req_wdata = d; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (req_ready !== 1'b0) begin
                errors++; $display("FAIL reset_ready_low cyc%0d got %b want 0", i, req_ready);
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({req_ready, OSPI_CS, OSPI_CLK, io_oe, rsp_valid, rsp_rdata, io_out} !== {5'b11000, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL reset_idle got rdy/cs/clk/oe/rsp=%b%b%b%b%b rdata=%h io=%h want 11000 00 00",
                     req_ready, OSPI_CS, OSPI_CLK, io_oe, rsp_valid, rsp_rdata, io_out);
        end
    endtask

    task automatic test_wren;
        logic [5:1] e_cs  = 5'b11100;
        logic [5:1] e_clk = 5'b00010;
        logic [5:1] e_oe  = 5'b00011;
        logic [5:1] e_rsp = 5'b00100;
        logic [5:1] e_rdy = 5'b10000;
        issue(2'b11, 8'h00, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if ({OSPI_CS, OSPI_CLK, io_oe, rsp_valid, req_ready} !== {e_cs[k], e_clk[k], e_oe[k], e_rsp[k], e_rdy[k]}) begin
                errors++;
                $display("FAIL wren_c%0d cs/clk/oe/rsp/rdy got %b%b%b%b%b want %b%b%b%b%b", k,
                         OSPI_CS, OSPI_CLK, io_oe, rsp_valid, req_ready, e_cs[k], e_clk[k], e_oe[k], e_rsp[k], e_rdy[k]);
            end
            if (e_oe[k]) begin
                checks++;
                if (io_out !== 8'h06) begin
                    errors++; $display("FAIL wren_io_c%0d got %h want 06", k, io_out);
                end
            end
            if (k < 5) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_write;
        logic [9:1] e_cs  = 9'b111000000;
        logic [9:1] e_clk = 9'b000101010;
        logic [9:1] e_oe  = 9'b000111111;
        logic [9:1] e_rsp = 9'b001000000;
        logic [9:1] e_rdy = 9'b100000000;
        logic [7:0] e_io [1:9] = '{8'h02, 8'h02, 8'h3C, 8'h3C, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00};
        issue(2'b01, 8'h3C, 8'hA5);
        for (int k = 1; k <= 9; k++) begin
            checks++;
            if ({OSPI_CS, OSPI_CLK, io_oe, rsp_valid, req_ready} !== {e_cs[k], e_clk[k], e_oe[k], e_rsp[k], e_rdy[k]}) begin
                errors++;
                $display("FAIL write_c%0d cs/clk/oe/rsp/rdy got %b%b%b%b%b want %b%b%b%b%b", k,
                         OSPI_CS, OSPI_CLK, io_oe, rsp_valid, req_ready, e_cs[k], e_clk[k], e_oe[k], e_rsp[k], e_rdy[k]);
            end
            if (e_oe[k]) begin
                checks++;
                if (io_out !== e_io[k]) begin
                    errors++; $display("FAIL write_io_c%0d got %h want %h", k, io_out, e_io[k]);
                end
            end
            if (k < 9) begin @(posedge clk); #1; end
        end
        checks++;
        if (mem[8'h3C] !== 8'hA5) begin
            errors++; $display("FAIL write_flash_mem got %h want a5", mem[8'h3C]);
        end
    endtask

    task automatic test_read;
        logic [17:1] e_cs  = 17'b111_00000000000000;
        logic [17:1] e_clk = 17'b000_10101010101010;
        logic [17:1] e_oe  = 17'b000_00000000001111;
        logic [17:1] e_rsp = 17'b001_00000000000000;
        logic [17:1] e_rdy = 17'b100_00000000000000;
        logic [7:0]  e_io [1:4] = '{8'h0B, 8'h0B, 8'h3C, 8'h3C};
        issue(2'b00, 8'h3C, 8'h77);
        for (int k = 1; k <= 17; k++) begin
            checks++;
            if ({OSPI_CS, OSPI_CLK, io_oe, rsp_valid, req_ready} !== {e_cs[k], e_clk[k], e_oe[k], e_rsp[k], e_rdy[k]}) begin
                errors++;
                $display("FAIL read_c%0d cs/clk/oe/rsp/rdy got %b%b%b%b%b want %b%b%b%b%b", k,
                         OSPI_CS, OSPI_CLK, io_oe, rsp_valid, req_ready, e_cs[k], e_clk[k], e_oe[k], e_rsp[k], e_rdy[k]);
            end
            if (k <= 4) begin
                checks++;
                if (io_out !== e_io[k]) begin
                    errors++; $display("FAIL read_io_c%0d got %h want %h", k, io_out, e_io[k]);
                end
            end
            if (k == 15 || k == 17) begin
                checks++;
                if (rsp_rdata !== 8'hA5) begin
                    errors++; $display("FAIL read_rdata_c%0d got %h want a5", k, rsp_rdata);
                end
            end
            if (k < 17) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_erase;
        logic [7:1] e_cs  = 7'b1110000;
        logic [7:1] e_clk = 7'b0001010;
        logic [7:1] e_oe  = 7'b0001111;
        logic [7:1] e_rsp = 7'b0010000;
        logic [7:1] e_rdy = 7'b1000000;
        logic [7:0] e_io [1:4] = '{8'h20, 8'h20, 8'h10, 8'h10};
        issue(2'b10, 8'h10, 8'h00);
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if ({OSPI_CS, OSPI_CLK, io_oe, rsp_valid, req_ready} !== {e_cs[k], e_clk[k], e_oe[k], e_rsp[k], e_rdy[k]}) begin
                errors++;
                $display("FAIL erase_c%0d cs/clk/oe/rsp/rdy got %b%b%b%b%b want %b%b%b%b%b", k,
                         OSPI_CS, OSPI_CLK, io_oe, rsp_valid, req_ready, e_cs[k], e_clk[k], e_oe[k], e_rsp[k], e_rdy[k]);
            end
            if (k <= 4) begin
                checks++;
                if (io_out !== e_io[k]) begin
                    errors++; $display("FAIL erase_io_c%0d got %h want %h", k, io_out, e_io[k]);
                end
            end
            if (k < 7) begin @(posedge clk); #1; end
        end
        issue(2'b00, 8'h10, 8'h00);
        for (int k = 1; k <= 17; k++) begin
            if (k == 15) begin
                checks++;
                if ({rsp_valid, rsp_rdata} !== {1'b1, 8'hFF}) begin
                    errors++; $display("FAIL erase_readback got vld=%b data=%h want vld=1 data=ff", rsp_valid, rsp_rdata);
                end
            end
            if (k < 17) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset_mid;
        issue(2'b00, 8'h3C, 8'h00);
        for (int k = 1; k < 6; k++) begin @(posedge clk); #1; end
        checks++;
        if ({OSPI_CS, io_oe} !== 2'b00) begin
            errors++; $display("FAIL midrst_pre cs/oe got %b%b want 00", OSPI_CS, io_oe);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({OSPI_CS, OSPI_CLK, io_oe, rsp_valid, req_ready, rsp_rdata} !== {5'b10000, 8'h00}) begin
            errors++;
            $display("FAIL midrst_idle cs/clk/oe/rsp/rdy got %b%b%b%b%b rdata=%h want 10000 00",
                     OSPI_CS, OSPI_CLK, io_oe, rsp_valid, req_ready, rsp_rdata);
        end
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({OSPI_CS, rsp_valid, req_ready} !== 3'b101) begin
                errors++; $display("FAIL midrst_after_c%0d cs/rsp/rdy got %b%b%b want 101", k, OSPI_CS, rsp_valid, req_ready);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [12:1] e_cs  = 12'b001110011100;
        logic [12:1] e_rsp = 12'b000010000100;
        logic [12:1] e_rdy = 12'b001000010000;
        bit          seen_ready;
        req_op = 2'b11; req_addr = 8'h00; req_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if ({OSPI_CS, rsp_valid, req_ready} !== {e_cs[k], e_rsp[k], e_rdy[k]}) begin
                errors++;
                $display("FAIL b2b_c%0d cs/rsp/rdy got %b%b%b want %b%b%b", k,
                         OSPI_CS, rsp_valid, req_ready, e_cs[k], e_rsp[k], e_rdy[k]);
            end
            if (k == 6) begin
                checks++;
                if (io_out !== 8'h06) begin
                    errors++; $display("FAIL b2b_io_c6 got %h want 06", io_out);
                end
            end
            if (k == 1) req_op = 2'b00;
            if (k == 5) req_op = 2'b11;
            if (k < 12) begin @(posedge clk); #1; end
        end
        req_valid = 1'b0;
        seen_ready = 1'b0;
        for (int i = 0; i < 20 && !seen_ready; i++) begin
            @(posedge clk); #1;
            seen_ready = req_ready;
        end
        checks++;
        if (seen_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_drain got ready=%b want 1 within 20 cycles", req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_wren();
        test_write();
        test_read();
        test_erase();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
